// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the register file and its write-port driver.
package reg_file_pkg;

    localparam int REG_WIDTH_DEF  = 32;
    localparam int ADDR_WIDTH_DEF = 4;

    typedef enum logic {INIT, RUN} wb_state_e;
    typedef enum logic {CH_ALU, CH_MEM} wb_chan_e;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is the ALU, bit 1 the load unit.
module wb_rr_arb2
    import reg_file_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    wb_chan_e prio;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = (prio == CH_ALU) ? 2'b01 : 2'b10;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    // The loser of any grant gets priority next time; idle cycles leave it alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prio <= CH_ALU;
        end else if (o_gnt != 2'b00) begin
            prio <= o_gnt[0] ? CH_MEM : CH_ALU;
        end
    end

endmodule

// File: rtl/reg_file_writer.sv
// Single write-port driver for reg_file: zero sweep after reset, then
// round-robin writeback from the ALU and load unit, one registered write per cycle.
module reg_file_writer
    import reg_file_pkg::*;
#(
    parameter int REG_WIDTH          = REG_WIDTH_DEF,
    parameter int ADDR_WIDTH         = ADDR_WIDTH_DEF,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [ADDR_WIDTH-1:0] i_alu_addr,
    input  logic [REG_WIDTH-1:0]  i_alu_val,
    input  logic                  i_mem_valid,
    output logic                  o_mem_ready,
    input  logic [ADDR_WIDTH-1:0] i_mem_addr,
    input  logic [REG_WIDTH-1:0]  i_mem_val,
    output logic [ADDR_WIDTH-1:0] o_reg_addr_w,
    output logic [REG_WIDTH-1:0]  o_reg_val_w,
    output logic                  o_write_en,
    output logic                  o_init_done
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    wb_state_e             state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;
    logic [1:0]            gnt;
    logic                  init_done_r;
    logic [ADDR_WIDTH-1:0] wr_addr_p1;
    logic [REG_WIDTH-1:0]  wr_val_p1;
    logic                  vld_p1;

    // A runtime write to register 0 is swallowed when it is hardwired.
    function automatic logic write_kept(input logic [ADDR_WIDTH-1:0] addr);
        return !(ZERO_REG_HARDWIRED && (addr == '0));
    endfunction

    wb_rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   ({i_mem_valid, i_alu_valid}),
        .i_en    (state == RUN),
        .o_gnt   (gnt)
    );

    assign o_alu_ready = gnt[0];
    assign o_mem_ready = gnt[1];

    // p0 -> p1: accepted request (or sweep entry) becomes the registered write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= INIT;
            sweep_cnt   <= '0;
            init_done_r <= 1'b0;
            wr_addr_p1  <= '0;
            wr_val_p1   <= '0;
            vld_p1      <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    vld_p1     <= 1'b1;
                    wr_addr_p1 <= sweep_cnt;
                    wr_val_p1  <= '0;
                    if (sweep_cnt == LAST_ADDR) begin
                        state       <= RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (gnt[0]) begin
                        wr_addr_p1 <= i_alu_addr;
                        wr_val_p1  <= i_alu_val;
                        vld_p1     <= write_kept(i_alu_addr);
                    end else if (gnt[1]) begin
                        wr_addr_p1 <= i_mem_addr;
                        wr_val_p1  <= i_mem_val;
                        vld_p1     <= write_kept(i_mem_addr);
                    end else begin
                        vld_p1 <= 1'b0;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    assign o_reg_addr_w = wr_addr_p1;
    assign o_reg_val_w  = wr_val_p1;
    assign o_write_en   = vld_p1;
    assign o_init_done  = init_done_r;

endmodule

// File: tb/tb_reg_file_writer.sv
// Directed bench for reg_file_writer with a behavioural reg_file (forwarding read port).
module tb_reg_file_writer;

    localparam int RW = 32;
    localparam int AW = 4;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_alu_valid;
    logic [AW-1:0] i_alu_addr;
    logic [RW-1:0] i_alu_val;
    logic          i_mem_valid;
    logic [AW-1:0] i_mem_addr;
    logic [RW-1:0] i_mem_val;

    logic          alu_ready, mem_ready, write_en, init_done;
    logic [AW-1:0] reg_addr_w;
    logic [RW-1:0] reg_val_w;

    logic          alu_ready2, mem_ready2, write_en2, init_done2;
    logic [AW-1:0] reg_addr_w2;
    logic [RW-1:0] reg_val_w2;

    int total;
    int bad;

    reg_file_writer #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .ZERO_REG_HARDWIRED(1'b1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_alu_valid(i_alu_valid), .o_alu_ready(alu_ready),
        .i_alu_addr(i_alu_addr), .i_alu_val(i_alu_val),
        .i_mem_valid(i_mem_valid), .o_mem_ready(mem_ready),
        .i_mem_addr(i_mem_addr), .i_mem_val(i_mem_val),
        .o_reg_addr_w(reg_addr_w), .o_reg_val_w(reg_val_w),
        .o_write_en(write_en), .o_init_done(init_done)
    );

    reg_file_writer #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .ZERO_REG_HARDWIRED(1'b0)) dut_nz (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_alu_valid(i_alu_valid), .o_alu_ready(alu_ready2),
        .i_alu_addr(i_alu_addr), .i_alu_val(i_alu_val),
        .i_mem_valid(i_mem_valid), .o_mem_ready(mem_ready2),
        .i_mem_addr(i_mem_addr), .i_mem_val(i_mem_val),
        .o_reg_addr_w(reg_addr_w2), .o_reg_val_w(reg_val_w2),
        .o_write_en(write_en2), .o_init_done(init_done2)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural reg_file: storage without reset, commit on clock, forwarding read.
    logic [RW-1:0] rf [16];
    always @(posedge i_clk) begin
        if (write_en) rf[reg_addr_w] <= reg_val_w;
    end

    function automatic logic [RW-1:0] rf_read(input logic [AW-1:0] a);
        if (write_en && (reg_addr_w == a)) return reg_val_w;
        return rf[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_write(input string tag, input logic [AW-1:0] a, input logic [RW-1:0] v);
        check({tag, "_we"}, 32'(write_en), 32'd1);
        check({tag, "_addr"}, 32'(reg_addr_w), 32'(a));
        check({tag, "_val"}, reg_val_w, v);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 32'(write_en), 32'd0);
        check({tag, "_addr"}, 32'(reg_addr_w), 32'd0);
        check({tag, "_val"}, reg_val_w, 32'd0);
        check({tag, "_done"}, 32'(init_done), 32'd0);
        check({tag, "_ardy"}, 32'(alu_ready), 32'd0);
        check({tag, "_mrdy"}, 32'(mem_ready), 32'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        i_rst_n = 1'b0;
        i_alu_valid = 1'b1;
        i_alu_addr = 4'd9;
        i_alu_val = 32'h99;
        i_mem_valid = 1'b0;
        i_mem_addr = '0;
        i_mem_val = '0;

        #3;
        check_reset_outputs("rst");
        #19;
        i_rst_n = 1'b1;

        // Partial sweep, then asynchronous reset just after addr 7 is shown.
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_write($sformatf("sweepA%0d", k), AW'(k - 1), '0);
            check("sweepA_ardy", 32'(alu_ready), 32'd0);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        #2;
        i_rst_n = 1'b1;

        // Full sweep with both producers already waiting.
        i_alu_valid = 1'b1; i_alu_addr = 4'd1; i_alu_val = 32'h111;
        i_mem_valid = 1'b1; i_mem_addr = 4'd2; i_mem_val = 32'h222;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_write($sformatf("sweepB%0d", k), AW'(k - 1), '0);
            check("sweepB_done", 32'(init_done), (k == 16) ? 32'd1 : 32'd0);
            check("sweepB_ardy", 32'(alu_ready), (k == 16) ? 32'd1 : 32'd0);
            check("sweepB_mrdy", 32'(mem_ready), 32'd0);
        end

        // Contention: ALU, MEM, ALU, MEM with no gaps.
        tick();
        check_write("cont1", 4'd1, 32'h111);
        i_alu_addr = 4'd3; i_alu_val = 32'h333;
        #1;
        check("cont1_mrdy", 32'(mem_ready), 32'd1);
        check("cont1_ardy", 32'(alu_ready), 32'd0);
        tick();
        check_write("cont2", 4'd2, 32'h222);
        i_mem_addr = 4'd4; i_mem_val = 32'h444;
        #1;
        check("cont2_ardy", 32'(alu_ready), 32'd1);
        tick();
        check_write("cont3", 4'd3, 32'h333);
        i_alu_valid = 1'b0;
        #1;
        check("cont3_mrdy", 32'(mem_ready), 32'd1);
        tick();
        check_write("cont4", 4'd4, 32'h444);
        i_mem_valid = 1'b0;
        tick();
        check("idle_we", 32'(write_en), 32'd0);
        check("idle_addr", 32'(reg_addr_w), 32'd4);
        check("idle_val", reg_val_w, 32'h444);

        // Load-unit stream while the ALU is idle.
        i_mem_valid = 1'b1; i_mem_addr = 4'd3; i_mem_val = 32'hA;
        #1;
        check("strm_mrdy", 32'(mem_ready), 32'd1);
        tick();
        check_write("strm1", 4'd3, 32'hA);
        i_mem_addr = 4'd4; i_mem_val = 32'hB;
        tick();
        check_write("strm2", 4'd4, 32'hB);
        i_mem_addr = 4'd5; i_mem_val = 32'hC;
        tick();
        check_write("strm3", 4'd5, 32'hC);
        i_alu_valid = 1'b1; i_alu_addr = 4'd6; i_alu_val = 32'h66;
        i_mem_addr = 4'd7; i_mem_val = 32'h77;
        #1;
        check("both_ardy", 32'(alu_ready), 32'd1);
        check("both_mrdy", 32'(mem_ready), 32'd0);
        tick();
        check_write("both1", 4'd6, 32'h66);
        i_alu_valid = 1'b0;
        tick();
        check_write("both2", 4'd7, 32'h77);
        i_mem_valid = 1'b0;

        // Register 0: dropped when hardwired, written otherwise.
        i_alu_valid = 1'b1; i_alu_addr = 4'd0; i_alu_val = 32'hDEAD;
        #1;
        check("zero_ardy", 32'(alu_ready), 32'd1);
        tick();
        i_alu_valid = 1'b0;
        check("zero_we_hw", 32'(write_en), 32'd0);
        check("zero_rd", rf_read(4'd0), 32'd0);
        check("zero_we_nz", 32'(write_en2), 32'd1);
        check("zero_addr_nz", 32'(reg_addr_w2), 32'd0);
        check("zero_val_nz", reg_val_w2, 32'hDEAD);

        // End-to-end through the reg_file read port.
        i_alu_valid = 1'b1; i_alu_addr = 4'd5; i_alu_val = 32'h1234;
        tick();
        i_alu_valid = 1'b0;
        check("e2e_rd1", rf_read(4'd5), 32'h1234);
        i_mem_valid = 1'b1; i_mem_addr = 4'd5; i_mem_val = 32'h5678;
        tick();
        i_mem_valid = 1'b0;
        check("e2e_rd2", rf_read(4'd5), 32'h5678);
        tick();
        check("e2e_idle_we", 32'(write_en), 32'd0);
        check("e2e_rd3", rf_read(4'd5), 32'h5678);
        check("e2e_rd_r4", rf_read(4'd4), 32'hB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish within 20000 time units");
        $fatal(1, "timeout");
    end

endmodule
